alu_uart_sequencer: RTL
=======================

Name: alu_uart_sequencer

Overview:
- Top-level control FSM between the UART receiver, the combinational ALU and the Tx interface buffer.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU inputs.
- Validates the opcode, then hands the ALU result to the Tx interface with a one-cycle ready pulse and waits for the transmitter to finish.
- Supervises inter-byte gaps with a timeout counter.

Parameters:
- DATA_WIDTH, 8, width of operands, ALU result and UART bytes.
- OP_WIDTH, 6, opcode width; taken from the low bits of the third received byte.
- TIMEOUT_CYCLES, 1000000, maximum i_clk cycles allowed between bytes of one frame.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  DATA_WIDTH  byte from the UART receiver.
- i_rx_done  in  1  one-cycle pulse; i_rx_data is valid on this cycle.
- i_alu_result  in  DATA_WIDTH  combinational ALU output.
- i_tx_full  in  1  Tx interface buffer occupied.
- i_tx_done  in  1  one-cycle pulse; transmitter finished a byte.
- o_data_a  out  DATA_WIDTH  registered operand A to the ALU.
- o_data_b  out  DATA_WIDTH  registered operand B to the ALU.
- o_op  out  OP_WIDTH  registered opcode to the ALU.
- o_result  out  DATA_WIDTH  registered result to the Tx interface data input.
- o_alu_result_ready  out  1  one-cycle write pulse to the Tx interface.
- o_busy  out  1  high whenever state is not IDLE.
- o_timeout  out  1  one-cycle pulse when a frame is aborted by timeout.
- o_op_error  out  1  one-cycle pulse when an invalid opcode is received.
- o_rx_overrun  out  1  one-cycle pulse when a byte arrives while busy executing or sending.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE, all outputs 0, timer 0. Reset asserted mid-frame aborts the frame immediately; no pulse is issued.
- States: IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- IDLE:
  - On i_rx_done: o_data_a <= i_rx_data, timer <= 0, go to WAIT_B.
- WAIT_B:
  - On i_rx_done: o_data_b <= i_rx_data, timer <= 0, go to WAIT_OP.
  - Otherwise timer increments.
- WAIT_OP:
  - On i_rx_done: o_op <= i_rx_data[OP_WIDTH-1:0], go to EXEC.
  - Otherwise timer increments.
- Timeout (WAIT_B or WAIT_OP only): when timer == TIMEOUT_CYCLES-1 with no i_rx_done, pulse o_timeout, go to IDLE.
  - o_data_a and o_data_b keep their values.
  - If i_rx_done arrives on that same cycle, the byte wins and no timeout is raised.
- EXEC (1 cycle; ALU inputs stable from the previous edge):
  - If o_op is valid: o_result <= i_alu_result, go to SEND.
  - If o_op is invalid: pulse o_op_error, go to IDLE with no transmission.
- SEND:
  - If i_tx_full=0: pulse o_alu_result_ready for exactly one cycle, go to WAIT_TX.
  - If i_tx_full=1: hold in SEND with no pulse until the buffer is free.
- WAIT_TX: on i_tx_done go to IDLE. No timeout in this state.
- i_rx_done in EXEC, SEND or WAIT_TX: byte discarded, o_rx_overrun pulsed, state unaffected.
- i_tx_done outside WAIT_TX: ignored.
- Latency: rising edge with the opcode byte -> EXEC next cycle -> o_alu_result_ready asserted 2 cycles after the opcode i_rx_done edge when i_tx_full=0.
- o_result is stable from the EXEC edge until the next frame's EXEC.
- Timer width: clog2(TIMEOUT_CYCLES). Timer saturates and never wraps.
- Valid opcodes: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams, shared with the ALU;
  - state encoding enum;
  - function is_valid_op.
- One natural sub-module: inter_byte_timer. Inputs: clear, count-enable. Output: expired, saturating at TIMEOUT_CYCLES-1.

Test Plan:
1. Rx bytes 0x05, 0x03, 0x20 (ADD) with ALU model, i_tx_full=0 -> o_result=0x08; o_alu_result_ready single pulse 2 cycles after the third i_rx_done; o_busy drops after i_tx_done.
2. Bytes 0x10, 0x01, op 0x3F -> o_op_error one pulse in EXEC cycle; no o_alu_result_ready; state IDLE.
3. Byte 0xAA, then silence with TIMEOUT_CYCLES=16 -> o_timeout pulse exactly 16 cycles after entering WAIT_B; o_data_a stays 0xAA; next byte is treated as operand A.
4. Valid frame with i_tx_full=1 held 5 cycles -> stays in SEND; o_alu_result_ready fires one cycle after i_tx_full falls.
5. Extra i_rx_done (0x77) during WAIT_TX -> o_rx_overrun pulse; o_data_a unchanged; frame completes normally.
6. Drive i_reset low while in WAIT_OP -> all outputs 0 asynchronously (before the next clock edge); after release, 0x02, 0x02, 0x22 (SUB) yields o_result=0x00.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions.
// Opcode values, FSM state encoding and opcode validity check.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Bundle between the sequencer and its UART Rx, ALU and Tx buffer.
// The slave side is the sequencer itself.
interface alu_uart_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_tx_full;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] o_data_a;
  logic [DATA_WIDTH-1:0] o_data_b;
  logic [OP_WIDTH-1:0]   o_op;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_alu_result_ready;
  logic                  o_busy;
  logic                  o_timeout;
  logic                  o_op_error;
  logic                  o_rx_overrun;

  modport master (
    output i_rx_data, i_rx_done, i_alu_result,
    output i_tx_full, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_result,
    input  o_alu_result_ready, o_busy, o_timeout,
    input  o_op_error, o_rx_overrun
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result,
    input  i_tx_full, i_tx_done,
    output o_data_a, o_data_b, o_op, o_result,
    output o_alu_result_ready, o_busy, o_timeout,
    output o_op_error, o_rx_overrun
  );
endinterface

// File: rtl/inter_byte_timer.sv
// Gap counter between bytes of one frame.
// Saturates at CYCLES-1 and flags expiry there.
module inter_byte_timer #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  // count enabled cycles, hold at LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer: A, B, opcode in; ALU result out to Tx.
// All pulse outputs are registered one-cycle strobes.
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          OP_WIDTH       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                 i_clk,
  input logic                 i_reset,
  alu_uart_sequencer_if.slave bus
);
  state_t state, state_n;

  logic [DATA_WIDTH-1:0] a_n, b_n, res_n;
  logic [OP_WIDTH-1:0]   op_n;
  logic rdy_n, tmo_n, err_n, ovr_n;
  logic clr, en, expired;

  inter_byte_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .clear  (clr),
    .en     (en),
    .expired(expired)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_n;
  end

  // next state, next datapath values and strobes
  always_comb begin
    state_n = state;
    a_n     = bus.o_data_a;
    b_n     = bus.o_data_b;
    op_n    = bus.o_op;
    res_n   = bus.o_result;
    rdy_n   = 1'b0;
    tmo_n   = 1'b0;
    err_n   = 1'b0;
    ovr_n   = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_rx_done) begin
          a_n     = bus.i_rx_data;
          clr     = 1'b1;
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.i_rx_done) begin
          b_n     = bus.i_rx_data;
          clr     = 1'b1;
          state_n = WAIT_OP;
        end else if (expired) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else begin
          en = 1'b1;
        end
      end
      WAIT_OP: begin
        if (bus.i_rx_done) begin
          op_n    = bus.i_rx_data[OP_WIDTH-1:0];
          state_n = EXEC;
        end else if (expired) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else begin
          en = 1'b1;
        end
      end
      EXEC: begin
        ovr_n = bus.i_rx_done;
        if (is_valid_op(bus.o_op)) begin
          res_n   = bus.i_alu_result;
          state_n = SEND;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      SEND: begin
        ovr_n = bus.i_rx_done;
        if (!bus.i_tx_full) begin
          rdy_n   = 1'b1;
          state_n = WAIT_TX;
        end
      end
      WAIT_TX: begin
        ovr_n = bus.i_rx_done;
        if (bus.i_tx_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // registered datapath and strobes
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bus.o_data_a           <= '0;
      bus.o_data_b           <= '0;
      bus.o_op               <= '0;
      bus.o_result           <= '0;
      bus.o_alu_result_ready <= 1'b0;
      bus.o_timeout          <= 1'b0;
      bus.o_op_error         <= 1'b0;
      bus.o_rx_overrun       <= 1'b0;
    end else begin
      bus.o_data_a           <= a_n;
      bus.o_data_b           <= b_n;
      bus.o_op               <= op_n;
      bus.o_result           <= res_n;
      bus.o_alu_result_ready <= rdy_n;
      bus.o_timeout          <= tmo_n;
      bus.o_op_error         <= err_n;
      bus.o_rx_overrun       <= ovr_n;
    end
  end

  assign bus.o_busy = (state != IDLE);
endmodule
